cv_ctrl_mux: RTL



---
 rtl/cv_ctrl_pkg.sv | 65 ++++++
 rtl/cv_ctrl_mux_if.sv | 25 ++
 rtl/cv_spinner_quad.sv | 57 +++++
 rtl/cv_ctrl_mux.sv | 109 ++++++++++
 4 files changed

// File: rtl/cv_ctrl_pkg.sv
// Shared constants and helpers for the ColecoVision controller-port engine:
// joystick bit map, keypad line codes and the quadrature phase sequence.
package cv_ctrl_pkg;

   localparam int unsigned JOY_W    = 32;
   localparam int unsigned JOY_USED = 20;

   localparam int unsigned JB_R      = 0;
   localparam int unsigned JB_L      = 1;
   localparam int unsigned JB_D      = 2;
   localparam int unsigned JB_U      = 3;
   localparam int unsigned JB_FIRE1  = 4;
   localparam int unsigned JB_FIRE2  = 5;
   localparam int unsigned JB_STAR   = 6;
   localparam int unsigned JB_HASH   = 7;
   localparam int unsigned JB_KEY0   = 8;
   localparam int unsigned JB_PURPLE = 18;
   localparam int unsigned JB_BLUE   = 19;

   localparam logic [3:0] KC_0      = 4'b0011;
   localparam logic [3:0] KC_1      = 4'b1110;
   localparam logic [3:0] KC_2      = 4'b1101;
   localparam logic [3:0] KC_3      = 4'b0110;
   localparam logic [3:0] KC_4      = 4'b0001;
   localparam logic [3:0] KC_5      = 4'b1001;
   localparam logic [3:0] KC_6      = 4'b0111;
   localparam logic [3:0] KC_7      = 4'b1100;
   localparam logic [3:0] KC_8      = 4'b1000;
   localparam logic [3:0] KC_9      = 4'b1011;
   localparam logic [3:0] KC_STAR   = 4'b1010;
   localparam logic [3:0] KC_HASH   = 4'b0101;
   localparam logic [3:0] KC_PURPLE = 4'b0100;
   localparam logic [3:0] KC_BLUE   = 4'b0010;
   localparam logic [3:0] KC_NONE   = 4'b1111;

   // Highest-priority pressed key wins: 0, 1..9, *, #, purple, blue.
   function automatic logic [3:0] kp_encode(input logic [JOY_USED-1:0] joy);
      if      (joy[JB_KEY0+0]) return KC_0;
      else if (joy[JB_KEY0+1]) return KC_1;
      else if (joy[JB_KEY0+2]) return KC_2;
      else if (joy[JB_KEY0+3]) return KC_3;
      else if (joy[JB_KEY0+4]) return KC_4;
      else if (joy[JB_KEY0+5]) return KC_5;
      else if (joy[JB_KEY0+6]) return KC_6;
      else if (joy[JB_KEY0+7]) return KC_7;
      else if (joy[JB_KEY0+8]) return KC_8;
      else if (joy[JB_KEY0+9]) return KC_9;
      else if (joy[JB_STAR])   return KC_STAR;
      else if (joy[JB_HASH])   return KC_HASH;
      else if (joy[JB_PURPLE]) return KC_PURPLE;
      else if (joy[JB_BLUE])   return KC_BLUE;
      else                     return KC_NONE;
   endfunction

   // Phase {A,B}; forward order 11 -> 10 -> 00 -> 01 -> 11.
   function automatic logic [1:0] quad_step(input logic [1:0] ph, input logic fwd);
      case (ph)
         2'b11:   return fwd ? 2'b10 : 2'b01;
         2'b10:   return fwd ? 2'b00 : 2'b11;
         2'b00:   return fwd ? 2'b01 : 2'b10;
         default: return fwd ? 2'b11 : 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/cv_ctrl_mux_if.sv
// Controller-port bus between the host joystick side and the console pins.
interface cv_ctrl_mux_if #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned SPIN_W    = 8
);
   logic [NUM_PORTS*32-1:0]     joy_i;
   logic [NUM_PORTS*SPIN_W-1:0] spin_i;
   logic [NUM_PORTS-1:0]        spin_stb_i;
   logic [NUM_PORTS-1:0]        sel_kp_n_i;
   logic [NUM_PORTS-1:0]        sel_joy_n_i;
   logic [NUM_PORTS*4-1:0]      ctrl_dir_o;
   logic [NUM_PORTS-1:0]        ctrl_p6_o;
   logic [NUM_PORTS-1:0]        ctrl_p7_o;
   logic [NUM_PORTS-1:0]        ctrl_p9_o;

   modport master (
      output joy_i, spin_i, spin_stb_i, sel_kp_n_i, sel_joy_n_i,
      input  ctrl_dir_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
   );

   modport slave (
      input  joy_i, spin_i, spin_stb_i, sel_kp_n_i, sel_joy_n_i,
      output ctrl_dir_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
   );
endinterface

// File: rtl/cv_spinner_quad.sv
// Roller/spinner emulation for one physical port: saturating delta
// accumulator drained one quadrature step per STEP_DIV ce_i pulses.
module cv_spinner_quad
   import cv_ctrl_pkg::*;
#(
   parameter int unsigned SPIN_W   = 8,
   parameter int unsigned STEP_DIV = 64
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce_i,
   input  logic [SPIN_W-1:0] spin_i,
   input  logic              spin_stb_i,
   output logic [1:0]        phase_o
);
   localparam int unsigned AW = SPIN_W + 2;
   localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic signed [AW:0] SAT_MAX = (AW+1)'((2 ** (SPIN_W + 1)) - 1);
   localparam logic signed [AW:0] SAT_MIN = -SAT_MAX;

   logic signed [AW-1:0] acc_q, acc_n;
   logic [DW-1:0]        div_q;
   logic [1:0]           phase_q;
   logic                 wrap_c, step_fwd_c, step_rev_c;
   logic signed [AW:0]   delta_c, adj_c, sum_c;

   // One extra bit of headroom so the sum can be clamped instead of wrapping.
   always_comb begin
      wrap_c     = ce_i && (div_q == DW'(STEP_DIV - 1));
      step_fwd_c = wrap_c && !acc_q[AW-1] && (acc_q != '0);
      step_rev_c = wrap_c && acc_q[AW-1];
      delta_c    = spin_stb_i ? (AW+1)'($signed(spin_i)) : '0;
      adj_c      = '0;
      if (step_fwd_c)      adj_c = '1;
      else if (step_rev_c) adj_c = (AW+1)'(1);
      sum_c = (AW+1)'(acc_q) + delta_c + adj_c;
      if (sum_c > SAT_MAX)      acc_n = SAT_MAX[AW-1:0];
      else if (sum_c < SAT_MIN) acc_n = SAT_MIN[AW-1:0];
      else                      acc_n = sum_c[AW-1:0];
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         div_q   <= '0;
         phase_q <= 2'b11;
      end else begin
         acc_q <= acc_n;
         if (ce_i) div_q <= wrap_c ? '0 : div_q + DW'(1);
         if (step_fwd_c)      phase_q <= quad_step(phase_q, 1'b1);
         else if (step_rev_c) phase_q <= quad_step(phase_q, 1'b0);
      end
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/cv_ctrl_mux.sv
// ColecoVision controller-port engine: rotatable joystick-to-port mapping,
// keypad encode with press hold, and per-port spinner quadrature.
module cv_ctrl_mux
   import cv_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned SPIN_W    = 8,
   parameter int unsigned STEP_DIV  = 64,
   parameter int unsigned HOLD_LEN  = 4096,
   localparam int unsigned ROT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             ce_i,
   input  logic [ROT_W-1:0] rotate_i,
   cv_ctrl_mux_if.slave     bus
);
   logic [JOY_USED-1:0] joy_phys   [NUM_PORTS];
   logic [1:0]          phase_phys [NUM_PORTS];
   logic [ROT_W-1:0]    rot_q;
   logic                rot_chg_c;

   assign rot_chg_c = (rotate_i != rot_q);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) rot_q <= '0;
      else       rot_q <= rotate_i;
   end

   // Spinner state belongs to the physical port and survives rotation.
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_phys
      logic [JOY_W-JOY_USED-1:0] unused_joy;
      assign joy_phys[i] = bus.joy_i[i*JOY_W +: JOY_USED];
      assign unused_joy  = bus.joy_i[i*JOY_W+JOY_USED +: JOY_W-JOY_USED];

      cv_spinner_quad #(
         .SPIN_W   (SPIN_W),
         .STEP_DIV (STEP_DIV)
      ) u_quad (
         .clk_sys    (clk_sys),
         .reset      (reset),
         .ce_i       (ce_i),
         .spin_i     (bus.spin_i[i*SPIN_W +: SPIN_W]),
         .spin_stb_i (bus.spin_stb_i[i]),
         .phase_o    (phase_phys[i])
      );
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_log
      logic [ROT_W:0]      idx_sum_c;
      logic [ROT_W-1:0]    phys_c;
      logic [JOY_USED-1:0] joy_c;
      logic [3:0]          code_c, latch_q, latch_n, kp_nib_c, js_nib_c, dir_q;
      logic [15:0]         cnt_q, cnt_n;
      logic                kp_p6_c, js_p6_c, p6_q, p7_q, p9_q;

      // Effective keypad code is taken from next-state so a press shows up
      // with the same one-cycle latency as the joystick lines.
      always_comb begin
         idx_sum_c = (ROT_W+1)'(k) + {1'b0, rotate_i};
         if (idx_sum_c >= (ROT_W+1)'(NUM_PORTS))
            phys_c = ROT_W'(idx_sum_c - (ROT_W+1)'(NUM_PORTS));
         else
            phys_c = ROT_W'(idx_sum_c);
         joy_c   = joy_phys[phys_c];
         code_c  = kp_encode(joy_c);
         latch_n = latch_q;
         cnt_n   = cnt_q;
         if (rot_chg_c) begin
            latch_n = KC_NONE;
            cnt_n   = '0;
         end else if (code_c != KC_NONE) begin
            latch_n = code_c;
            cnt_n   = 16'(HOLD_LEN);
         end else if (ce_i && (cnt_q != '0)) begin
            cnt_n = cnt_q - 16'd1;
         end
         kp_nib_c = (!bus.sel_kp_n_i[k] && (cnt_n != '0)) ? latch_n : KC_NONE;
         kp_p6_c  = bus.sel_kp_n_i[k] | ~joy_c[JB_FIRE2];
         js_nib_c = bus.sel_joy_n_i[k] ? KC_NONE :
                    ~{joy_c[JB_U], joy_c[JB_R], joy_c[JB_D], joy_c[JB_L]};
         js_p6_c  = bus.sel_joy_n_i[k] | ~joy_c[JB_FIRE1];
      end

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            latch_q <= KC_NONE;
            cnt_q   <= '0;
            dir_q   <= 4'b1111;
            p6_q    <= 1'b1;
            p7_q    <= 1'b1;
            p9_q    <= 1'b1;
         end else begin
            latch_q <= latch_n;
            cnt_q   <= cnt_n;
            dir_q   <= kp_nib_c & js_nib_c;
            p6_q    <= kp_p6_c & js_p6_c;
            p9_q    <= phase_phys[phys_c][1];
            p7_q    <= phase_phys[phys_c][0];
         end
      end

      assign bus.ctrl_dir_o[k*4 +: 4] = dir_q;
      assign bus.ctrl_p6_o[k]         = p6_q;
      assign bus.ctrl_p7_o[k]         = p7_q;
      assign bus.ctrl_p9_o[k]         = p9_q;
   end

endmodule
